// File: rtl/dmem_arbiter_if.sv
// External (loader/debug) access channel into the data-memory arbiter.
// The requester drives through master; the arbiter responds through slave.
interface dmem_arbiter_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  ext_req;
    logic                  ext_we;
    logic [DM_ADDRESS-1:0] ext_addr;
    logic [DATA_W-1:0]     ext_wdata;
    logic [2:0]            ext_funct3;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic [DATA_W-1:0]     ext_rdata;

    modport master (
        output ext_req, ext_we, ext_addr, ext_wdata, ext_funct3,
        input  ext_gnt, ext_rvalid, ext_rdata
    );

    modport slave (
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_funct3,
        output ext_gnt, ext_rvalid, ext_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage and an external requester,
// forcing a one-cycle core stall when the external side has waited too long.
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS   = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_mem_read,
    input  logic                  core_mem_write,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    dmem_arbiter_if.slave         ext,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [15:0]           force_count
);
    typedef enum logic {NORMAL, FORCE} state_t;

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              core_act;
    logic              core_own;
    logic              ext_own;
    logic              denied;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign core_act = core_mem_read | core_mem_write;

    always_comb begin
        core_own   = 1'b0;
        ext_own    = 1'b0;
        core_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        core_rdata = '0;
        if (!reset) begin
            core_stall = (state == FORCE);
            core_own   = (state == NORMAL) && core_act;
            ext_own    = ext.ext_req && ((state == FORCE) || !core_act);
        end
        if (core_own) begin
            // a simultaneous read+write is treated as a write
            mem_write  = core_mem_write;
            mem_read   = core_mem_read && !core_mem_write;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_funct3 = core_funct3;
            core_rdata = mem_rdata;
        end else if (ext_own) begin
            mem_write  = ext.ext_we;
            mem_read   = !ext.ext_we;
            mem_addr   = ext.ext_addr;
            mem_wdata  = ext.ext_wdata;
            mem_funct3 = ext.ext_funct3;
        end
    end

    assign ext.ext_gnt    = ext_own;
    assign ext.ext_rvalid = rvalid_q;
    assign ext.ext_rdata  = rdata_q;
    assign denied         = ext.ext_req && !ext_own;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= NORMAL;
            wait_cnt    <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            force_count <= '0;
        end else begin
            rvalid_q <= ext_own && !ext.ext_we;
            if (ext_own && !ext.ext_we)
                rdata_q <= mem_rdata;

            unique case (state)
                NORMAL: begin
                    if (denied) begin
                        // force_count is bumped on entry so it already reads
                        // the new value during the FORCE cycle itself
                        if (wait_cnt == LIMIT_M1) begin
                            state    <= FORCE;
                            wait_cnt <= '0;
                            if (force_count != '1)
                                force_count <= force_count + 16'd1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                FORCE: begin
                    state    <= NORMAL;
                    wait_cnt <= '0;
                end
                default: state <= NORMAL;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with STARVE_LIMIT = 4.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_mem_read, core_mem_write;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        mem_read, mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic [15:0] force_count;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) ext_bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ext(ext_bus.slave),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .force_count(force_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic c_rd, c_wr; logic [8:0] c_addr; logic [31:0] c_wdata; logic [2:0] c_f3;
        logic e_req, e_we; logic [8:0] e_addr; logic [31:0] e_wdata; logic [2:0] e_f3;
        logic [31:0] m_rdata;
        logic x_rd, x_wr; logic [8:0] x_addr; logic [31:0] x_wdata; logic [2:0] x_f3;
        logic x_gnt; logic [31:0] x_crdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        core_mem_read = 0; core_mem_write = 0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
        ext_bus.ext_req = 0; ext_bus.ext_we = 0; ext_bus.ext_addr = '0;
        ext_bus.ext_wdata = '0; ext_bus.ext_funct3 = '0; mem_rdata = '0;
    endtask

    task automatic idle();
        tick();
        clear_inputs();
        samp();
    endtask

    task automatic ext_drive(input logic req, input logic we, input logic [8:0] a, input logic [31:0] d);
        ext_bus.ext_req = req; ext_bus.ext_we = we; ext_bus.ext_addr = a;
        ext_bus.ext_wdata = d; ext_bus.ext_funct3 = 3'd2;
    endtask

    // Four denied cycles, then returns positioned in the FORCE cycle (after #1).
    task automatic contend_to_force(input string tag);
        tick();
        core_mem_read = 1; core_addr = 9'h070;
        ext_drive(1, 0, 9'h021, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            samp();
            chk($sformatf("%s denied%0d gnt", tag, k), 32'(ext_bus.ext_gnt), 32'd0);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,0,9'h000,32'h0,3'd0, 0,0,9'h000,32'h0,3'd0, 32'h11111111,
                    0,0,9'h000,32'h0,3'd0, 0,32'h0};
        vecs[1] = '{1,0,9'h055,32'hAAAA0001,3'd2, 0,0,9'h000,32'h0,3'd0, 32'h12345678,
                    1,0,9'h055,32'hAAAA0001,3'd2, 0,32'h12345678};
        vecs[2] = '{0,1,9'h1FF,32'hCAFEF00D,3'd0, 1,0,9'h044,32'h0,3'd2, 32'h0BADBEEF,
                    0,1,9'h1FF,32'hCAFEF00D,3'd0, 0,32'h0BADBEEF};
        vecs[3] = '{1,1,9'h003,32'h11112222,3'd1, 0,0,9'h000,32'h0,3'd0, 32'h0,
                    0,1,9'h003,32'h11112222,3'd1, 0,32'h0};
        vecs[4] = '{0,0,9'h0F0,32'h99999999,3'd5, 1,1,9'h100,32'h5A5A5A5A,3'd2, 32'h77777777,
                    0,1,9'h100,32'h5A5A5A5A,3'd2, 1,32'h0};
        vecs[5] = '{0,0,9'h000,32'h0,3'd0, 1,0,9'h0AA,32'h00000001,3'd4, 32'h33333333,
                    1,0,9'h0AA,32'h00000001,3'd4, 1,32'h0};
        vecs[6] = '{0,0,9'h012,32'h1,3'd3, 0,1,9'h0AB,32'hFFFFFFFF,3'd7, 32'h44444444,
                    0,0,9'h000,32'h0,3'd0, 0,32'h0};

        // Reset: outputs gated even with activity on the inputs
        clear_inputs();
        reset = 1;
        core_mem_read = 1; ext_drive(1, 0, 9'h010, 32'h0); mem_rdata = 32'h55AA55AA;
        samp();
        chk("rst mem_read", 32'(mem_read), 32'd0);
        chk("rst mem_write", 32'(mem_write), 32'd0);
        chk("rst ext_gnt", 32'(ext_bus.ext_gnt), 32'd0);
        chk("rst core_stall", 32'(core_stall), 32'd0);
        chk("rst core_rdata", core_rdata, 32'd0);
        tick(); tick();
        chk("rst ext_rvalid", 32'(ext_bus.ext_rvalid), 32'd0);
        chk("rst ext_rdata", ext_bus.ext_rdata, 32'd0);
        chk("rst force_count", 32'(force_count), 32'd0);
        clear_inputs();
        reset = 0;
        samp();

        for (int i = 0; i < 7; i++) begin
            tick();
            core_mem_read = vecs[i].c_rd; core_mem_write = vecs[i].c_wr;
            core_addr = vecs[i].c_addr; core_wdata = vecs[i].c_wdata; core_funct3 = vecs[i].c_f3;
            ext_bus.ext_req = vecs[i].e_req; ext_bus.ext_we = vecs[i].e_we;
            ext_bus.ext_addr = vecs[i].e_addr; ext_bus.ext_wdata = vecs[i].e_wdata;
            ext_bus.ext_funct3 = vecs[i].e_f3; mem_rdata = vecs[i].m_rdata;
            samp();
            chk($sformatf("vec%0d mem_read", i), 32'(mem_read), 32'(vecs[i].x_rd));
            chk($sformatf("vec%0d mem_write", i), 32'(mem_write), 32'(vecs[i].x_wr));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].x_addr));
            chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].x_wdata);
            chk($sformatf("vec%0d mem_funct3", i), 32'(mem_funct3), 32'(vecs[i].x_f3));
            chk($sformatf("vec%0d ext_gnt", i), 32'(ext_bus.ext_gnt), 32'(vecs[i].x_gnt));
            chk($sformatf("vec%0d core_rdata", i), core_rdata, vecs[i].x_crdata);
            chk($sformatf("vec%0d core_stall", i), 32'(core_stall), 32'd0);
            idle();
        end

        // External read on idle core, data one cycle later
        idle();
        tick();
        ext_drive(1, 0, 9'h010, 32'h0); mem_rdata = 32'hDEADBEEF;
        samp();
        chk("xrd gnt", 32'(ext_bus.ext_gnt), 32'd1);
        chk("xrd mem_addr", 32'(mem_addr), 32'h010);
        tick();
        clear_inputs();
        samp();
        chk("xrd rvalid", 32'(ext_bus.ext_rvalid), 32'd1);
        chk("xrd rdata", ext_bus.ext_rdata, 32'hDEADBEEF);
        tick();
        samp();
        chk("xrd rvalid drop", 32'(ext_bus.ext_rvalid), 32'd0);
        chk("xrd rdata hold", ext_bus.ext_rdata, 32'hDEADBEEF);

        // Core write wins, external granted on first idle core cycle
        tick();
        core_mem_write = 1; core_addr = 9'h0C3; core_wdata = 32'h01020304;
        ext_drive(1, 1, 9'h066, 32'hF00DF00D);
        samp();
        chk("coll mem_write", 32'(mem_write), 32'd1);
        chk("coll mem_addr", 32'(mem_addr), 32'h0C3);
        chk("coll gnt", 32'(ext_bus.ext_gnt), 32'd0);
        tick();
        core_mem_write = 0;
        samp();
        chk("coll late gnt", 32'(ext_bus.ext_gnt), 32'd1);
        chk("coll late addr", 32'(mem_addr), 32'h066);
        chk("coll late wdata", mem_wdata, 32'hF00DF00D);
        tick();
        clear_inputs();
        samp();
        chk("xwr no rvalid", 32'(ext_bus.ext_rvalid), 32'd0);

        // Back-to-back external reads
        tick();
        ext_drive(1, 0, 9'h001, 32'h0); mem_rdata = 32'hA1A1A1A1;
        samp();
        chk("b2b gnt1", 32'(ext_bus.ext_gnt), 32'd1);
        tick();
        ext_drive(1, 0, 9'h002, 32'h0); mem_rdata = 32'hB2B2B2B2;
        samp();
        chk("b2b gnt2", 32'(ext_bus.ext_gnt), 32'd1);
        chk("b2b rvalid1", 32'(ext_bus.ext_rvalid), 32'd1);
        chk("b2b rdata1", ext_bus.ext_rdata, 32'hA1A1A1A1);
        tick();
        clear_inputs();
        samp();
        chk("b2b rvalid2", 32'(ext_bus.ext_rvalid), 32'd1);
        chk("b2b rdata2", ext_bus.ext_rdata, 32'hB2B2B2B2);

        // Sustained contention: FORCE every 5th cycle
        idle();
        tick();
        core_mem_read = 1; core_addr = 9'h070;
        ext_drive(1, 0, 9'h020, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) tick();
            samp();
            chk($sformatf("cont%0d gnt", i), 32'(ext_bus.ext_gnt), 32'((i % 5) == 0));
            chk($sformatf("cont%0d stall", i), 32'(core_stall), 32'((i % 5) == 0));
            chk($sformatf("cont%0d addr", i), 32'(mem_addr), ((i % 5) == 0) ? 32'h020 : 32'h070);
            chk($sformatf("cont%0d fcnt", i), 32'(force_count), 32'(i / 5));
        end
        tick();
        samp();
        chk("cont21 core owns", 32'(mem_addr), 32'h070);
        chk("cont21 stall", 32'(core_stall), 32'd0);

        // FORCE with the request withdrawn
        idle();
        contend_to_force("drop");
        ext_bus.ext_req = 0;
        samp();
        chk("drop stall", 32'(core_stall), 32'd1);
        chk("drop mem_read", 32'(mem_read), 32'd0);
        chk("drop mem_write", 32'(mem_write), 32'd0);
        chk("drop gnt", 32'(ext_bus.ext_gnt), 32'd0);
        chk("drop fcnt", 32'(force_count), 32'd5);
        tick();
        samp();
        chk("drop after stall", 32'(core_stall), 32'd0);
        chk("drop after mem_read", 32'(mem_read), 32'd1);

        // Reset landing in FORCE
        idle();
        contend_to_force("rstf");
        samp();
        chk("rstf stall", 32'(core_stall), 32'd1);
        chk("rstf fcnt", 32'(force_count), 32'd6);
        reset = 1;
        #1;
        chk("rstf gnt killed", 32'(ext_bus.ext_gnt), 32'd0);
        tick();
        reset = 0;
        samp();
        chk("rstf after stall", 32'(core_stall), 32'd0);
        chk("rstf after rvalid", 32'(ext_bus.ext_rvalid), 32'd0);
        chk("rstf after fcnt", 32'(force_count), 32'd0);
        chk("rstf after gnt", 32'(ext_bus.ext_gnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
